// File: rtl/flash_boot_loader.sv
// flash_boot_loader
//
// Copies a boot image from a SPI NOR flash into SRAM after reset, then releases the cores.
// Sequence: READ command (0x03) + 24-bit address, then BOOT_WORDS little-endian 32-bit words.
// Each word is written to SRAM through a ready/valid style write port. SCK pauses (CSB held low)
// while a write is pending.
//
// Optional feature: define BOOT_CHECKSUM_EN to read one extra word after the image. That word is
// compared against the 32-bit wrap-around sum of the image words. A match boots the cores; a
// mismatch raises boot_err_o.
//
// Ports:
//   clk_i, reset_i              clock, asynchronous active-high reset
//   spi_sck_o, spi_mosi_o       SPI mode-0 clock (idle low) and command/address out
//   spi_miso_i, flash_csb_o     flash data in, active-low chip select
//   sram_wr_en_o, sram_addr_o,  SRAM write request, byte address, data;
//   sram_data_o, sram_ready_i   the write completes in a cycle with sram_ready_i high
//   restart_i                   re-run the boot (honoured only in DONE/ERROR)
//   cores_en_o                  per-core enable, CORE_EN_MASK once booted
//   boot_done_o, boot_err_o     boot status
module flash_boot_loader #(
    parameter int unsigned          BOOT_WORDS      = 32,
    parameter logic [23:0]          FLASH_BASE_ADDR = 24'h00_0000,
    parameter logic [31:0]          SRAM_BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned          NUM_CORES       = 2,
    parameter logic [NUM_CORES-1:0] CORE_EN_MASK    = '1,
    parameter int unsigned          SCK_DIV         = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 spi_sck_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i,
    output logic                 flash_csb_o,
    output logic                 sram_wr_en_o,
    output logic [31:0]          sram_addr_o,
    output logic [31:0]          sram_data_o,
    input  logic                 sram_ready_i,
    input  logic                 restart_i,
    output logic [NUM_CORES-1:0] cores_en_o,
    output logic                 boot_done_o,
    output logic                 boot_err_o
);

`ifdef BOOT_CHECKSUM_EN
    localparam int unsigned TotalWords = BOOT_WORDS + 1;
`else
    localparam int unsigned TotalWords = BOOT_WORDS;
`endif
    localparam int unsigned WordW = $clog2(TotalWords + 1);
    localparam int unsigned DivW  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned HoldW = $clog2(2 * SCK_DIV);

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StWrite,
        StCsHold,   // CSB high for 2*SCK_DIV cycles after the transfer
        StCheck,
        StDone,
        StError
    } state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [DivW-1:0]    r_div;
    logic               r_sck;
    logic [4:0]         r_bit_cnt;
    logic [WordW-1:0]   r_word_cnt;
    logic [HoldW-1:0]   r_hold_cnt;
    logic [31:0]        r_tx;
    logic [31:0]        r_rx;
    logic               r_wr_en;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]        r_sum;
    logic [31:0]        r_chk;
`endif

    logic        w_shifting;
    logic        w_tick;
    logic        w_fall;
    logic        w_last_bit;
    logic        w_phase_end;
    logic        w_last_word;
    logic        w_chk_word;
    logic        w_start;
    logic [31:0] w_rx_word;
    logic [31:0] w_wr_addr;

    assign w_shifting  = (r_state == StCmd) || (r_state == StAddr) || (r_state == StData);
    assign w_tick      = w_shifting && (r_div == DivW'(SCK_DIV - 1));
    assign w_fall      = w_tick && r_sck;
    assign w_phase_end = w_fall && w_last_bit;
    assign w_last_word = (r_word_cnt == WordW'(BOOT_WORDS - 1));
`ifdef BOOT_CHECKSUM_EN
    // All image words written: the word now being read is the checksum.
    assign w_chk_word  = (r_word_cnt == WordW'(BOOT_WORDS));
`else
    assign w_chk_word  = 1'b0;
`endif
    // Leaving IDLE/DONE/ERROR for CMD starts a fresh boot.
    assign w_start     = (w_state_d == StCmd) && (r_state != StCmd);
    // Bytes arrive MSB-first, byte 0 first; byte 0 lands in [7:0].
    assign w_rx_word   = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
    assign w_wr_addr   = SRAM_BASE_ADDR + (32'(r_word_cnt) << 2);

    always_comb begin
        w_last_bit = 1'b0;
        case (r_state)
            StCmd:   w_last_bit = (r_bit_cnt == 5'd7);
            StAddr:  w_last_bit = (r_bit_cnt == 5'd23);
            StData:  w_last_bit = (r_bit_cnt == 5'd31);
            default: w_last_bit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  w_state_d = StCmd;
            StCmd:   if (w_phase_end) w_state_d = StAddr;
            StAddr:  if (w_phase_end) w_state_d = StData;
            StData:  if (w_phase_end) w_state_d = w_chk_word ? StCsHold : StWrite;
            StWrite: begin
                if (sram_ready_i) begin
`ifdef BOOT_CHECKSUM_EN
                    w_state_d = StData;
`else
                    w_state_d = w_last_word ? StCsHold : StData;
`endif
                end
            end
            StCsHold: begin
                if (r_hold_cnt == HoldW'(2 * SCK_DIV - 1)) begin
`ifdef BOOT_CHECKSUM_EN
                    w_state_d = StCheck;
`else
                    w_state_d = StDone;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            StCheck: w_state_d = (r_sum == r_chk) ? StDone : StError;
`else
            StCheck: w_state_d = StDone;
`endif
            StDone, StError: if (restart_i) w_state_d = StCmd;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_div      <= '0;
            r_sck      <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_hold_cnt <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum      <= '0;
            r_chk      <= '0;
`endif
        end else if (w_start) begin
            r_div      <= '0;
            r_sck      <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_hold_cnt <= '0;
            r_tx       <= {8'h03, 24'h00_0000};
            r_wr_en    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            case (r_state)
                StCmd, StAddr, StData: begin
                    if (w_tick) begin
                        r_div <= '0;
                        r_sck <= ~r_sck;
                        if (!r_sck) begin
                            // Rising edge: sample flash data.
                            if (r_state == StData) r_rx <= {r_rx[30:0], spi_miso_i};
                        end else if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            r_tx      <= (r_state == StCmd) ? {FLASH_BASE_ADDR, 8'h00} : '0;
                            if (r_state == StData && !w_chk_word) begin
                                r_wr_en <= 1'b1;
                                r_addr  <= w_wr_addr;
                                r_data  <= w_rx_word;
                            end
`ifdef BOOT_CHECKSUM_EN
                            if (r_state == StData && w_chk_word) r_chk <= w_rx_word;
`endif
                        end else begin
                            // Falling edge: present the next MOSI bit while SCK is low.
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_tx      <= {r_tx[30:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + DivW'(1);
                    end
                end
                StWrite: begin
                    if (sram_ready_i) begin
                        r_wr_en    <= 1'b0;
                        r_word_cnt <= r_word_cnt + WordW'(1);
`ifdef BOOT_CHECKSUM_EN
                        r_sum      <= r_sum + r_data;
`endif
                    end
                end
                StCsHold: r_hold_cnt <= r_hold_cnt + HoldW'(1);
                default: ;
            endcase
        end
    end

    assign spi_sck_o    = r_sck;
    assign spi_mosi_o   = ((r_state == StCmd) || (r_state == StAddr)) ? r_tx[31] : 1'b0;
    assign flash_csb_o  = !(w_shifting || (r_state == StWrite));
    assign sram_wr_en_o = r_wr_en;
    assign sram_addr_o  = r_addr;
    assign sram_data_o  = r_data;
    assign cores_en_o   = (r_state == StDone) ? CORE_EN_MASK : '0;
    assign boot_done_o  = (r_state == StDone);
`ifdef BOOT_CHECKSUM_EN
    assign boot_err_o   = (r_state == StError);
`else
    assign boot_err_o   = 1'b0;
`endif

endmodule
